// File: rtl/i2c_csr_bridge_pkg.sv
// Shared definitions for the I2C-to-CSR bridge: bus widths and FSM state encoding.
package i2c_csr_bridge_pkg;

  localparam int unsigned CsrAw = 5;
  localparam int unsigned CsrDw = 8;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck
  } state_e;

endpackage

// File: rtl/i2c_csr_bridge_sync_edge.sv
// Pin conditioning for SCL and SDA: 2-FF synchronizer plus a delay stage per pin,
// yielding SCL edges, START/STOP conditions and the synchronized SDA level.
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // Bit 0 carries SCL, bit 1 carries SDA; both pins share the same pipeline.
  logic [1:0] s1_q, s2_q, s3_q;
  logic [1:0] rise, fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
      s3_q <= 2'b11;
    end else begin
      s1_q <= {sda_i, scl_i};
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
  end

  assign sda_lvl_o  = s2_q[1];
  assign scl_rise_o = rise[0];
  assign scl_fall_o = fall[0];
  assign start_o    = fall[1] & s2_q[0];
  assign stop_o     = rise[1] & s2_q[0];

endmodule

// File: rtl/i2c_csr_bridge.sv
// I2C target that turns register-pointer/data transactions into CSR bus
// writes and reads, with pointer auto-increment in both directions.
module i2c_csr_bridge
  import i2c_csr_bridge_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h4a
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [CsrAw-1:0] csr_a,
  output logic [CsrDw-1:0] csr_do,
  output logic             csr_we,
  input  logic [CsrDw-1:0] csr_di
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge u_sync (
    .clk_i     (clk),
    .rst_ni    (rst),
    .scl_i     (scl_in),
    .sda_i     (sda_in),
    .sda_lvl_o (sda_lvl),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [7:0]       rx_q;
  logic [6:0]       tx_q;
  logic             rw_q;
  logic [CsrAw-1:0] ptr_q;
  logic             oe_q;
  logic             we_q;
  logic [CsrDw-1:0] do_q;
  logic [7:0]       rx_next;

  assign rx_next = {rx_q[6:0], sda_lvl};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rx_q    <= 8'd0;
      tx_q    <= 7'd0;
      rw_q    <= 1'b0;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      do_q    <= '0;
    end else begin
      // Pointer advances in the cycle after the write strobe so csr_a is stable during it.
      if (we_q) begin
        we_q  <= 1'b0;
        ptr_q <= ptr_q + 5'd1;
      end
      if (start_det) begin
        state_q <= StAddr;
        cnt_q   <= 4'd0;
        oe_q    <= 1'b0;
      end else if (stop_det) begin
        state_q <= StIdle;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: ;
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              rx_q  <= rx_next;
              cnt_q <= cnt_q + 4'd1;
              if (state_q == StWdata && cnt_q == 4'd7) begin
                we_q <= 1'b1;
                do_q <= rx_next;
              end
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q <= 4'd0;
              if (state_q == StAddr) begin
                if (rx_q[7:1] == I2C_ADDR) begin
                  state_q <= StAddrAck;
                  rw_q    <= rx_q[0];
                  oe_q    <= 1'b1;
                end else begin
                  state_q <= StIdle;
                end
              end else if (state_q == StPtr) begin
                ptr_q   <= rx_q[4:0];
                state_q <= StPtrAck;
                oe_q    <= 1'b1;
              end else begin
                state_q <= StWdataAck;
                oe_q    <= 1'b1;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              cnt_q <= 4'd0;
              if (rw_q) begin
                tx_q    <= csr_di[6:0];
                oe_q    <= ~csr_di[7];
                ptr_q   <= ptr_q + 5'd1;
                state_q <= StRdata;
              end else begin
                oe_q    <= 1'b0;
                state_q <= StPtr;
              end
            end
          end
          StPtrAck, StWdataAck: begin
            if (scl_fall) begin
              cnt_q   <= 4'd0;
              oe_q    <= 1'b0;
              state_q <= StWdata;
            end
          end
          StRdata: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                cnt_q   <= 4'd0;
                oe_q    <= 1'b0;
                state_q <= StRdataAck;
              end else begin
                oe_q <= ~tx_q[6];
                tx_q <= {tx_q[5:0], 1'b0};
              end
            end
          end
          StRdataAck: begin
            if (scl_rise) begin
              rx_q <= rx_next;
            end else if (scl_fall) begin
              cnt_q <= 4'd0;
              if (!rx_q[0]) begin
                tx_q    <= csr_di[6:0];
                oe_q    <= ~csr_di[7];
                ptr_q   <= ptr_q + 5'd1;
                state_q <= StRdata;
              end else begin
                state_q <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sda_oe = oe_q;
  assign csr_a  = ptr_q;
  assign csr_do = do_q;
  assign csr_we = we_q;

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// Directed bench for i2c_csr_bridge: bit-banged I2C controller, CSR write logger,
// and a read-data model of 0x80 | csr_a.
module tb_i2c_csr_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_oe, csr_we;
  logic [4:0] csr_a;
  logic [7:0] csr_do, csr_di;
  logic       sda_bus;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;
  assign csr_di  = 8'h80 | {3'b000, csr_a};

  i2c_csr_bridge #(.I2C_ADDR(7'h4a)) dut (
    .clk   (clk),
    .rst   (rst),
    .scl_in(scl_m),
    .sda_in(sda_bus),
    .sda_oe(sda_oe),
    .csr_a (csr_a),
    .csr_do(csr_do),
    .csr_we(csr_we),
    .csr_di(csr_di)
  );

  int         n_assert = 0;
  int         n_fail = 0;
  int         we_cnt = 0;
  bit         oe_seen = 1'b0;
  logic [4:0] we_a[$];
  logic [7:0] we_d[$];

  always @(negedge clk) begin
    if (csr_we) begin
      we_cnt++;
      we_a.push_back(csr_a);
      we_d.push_back(csr_do);
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    we_cnt = 0;
    we_a.delete();
    we_d.delete();
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(4);
    scl_m = 1'b1; tick(4);
    sda_m = 1'b0; tick(4);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(4);
    scl_m = 1'b1; tick(4);
    sda_m = 1'b1; tick(8);
  endtask

  task automatic bit_c(input logic b, output logic r);
    sda_m = b;    tick(4);
    scl_m = 1'b1; tick(4);
    r = sda_bus;  tick(4);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_c(b[i], r);
    bit_c(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_c(1'b1, r);
      d[i] = r;
    end
    bit_c(~ack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    logic [7:0] b;
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    chk("reset_sda_oe", 32'(sda_oe), 32'h0);
    chk("reset_csr_we", 32'(csr_we), 32'h0);
    chk("reset_csr_a",  32'(csr_a),  32'h0);
    chk("reset_csr_do", 32'(csr_do), 32'h0);
    rst = 1'b1;
    tick(4);

    // Single write: ptr 3, data 0x5a
    clear_log();
    start_c();
    send_byte(8'h94, ack); chk("w1_addr_ack", 32'(ack), 32'h1);
    send_byte(8'h03, ack); chk("w1_ptr_ack",  32'(ack), 32'h1);
    send_byte(8'h5a, ack); chk("w1_data_ack", 32'(ack), 32'h1);
    stop_c();
    chk("w1_we_cnt", 32'(we_cnt), 32'd1);
    chk("w1_we_a",   32'(we_a[0]), 32'h03);
    chk("w1_we_d",   32'(we_d[0]), 32'h5a);
    chk("w1_ptr",    32'(csr_a), 32'h04);

    // Pointer wrap: writes at 31 then 0
    clear_log();
    start_c();
    send_byte(8'h94, ack);
    send_byte(8'h1f, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack); chk("w2_data2_ack", 32'(ack), 32'h1);
    stop_c();
    chk("w2_we_cnt", 32'(we_cnt), 32'd2);
    chk("w2_we_a0",  32'(we_a[0]), 32'h1f);
    chk("w2_we_d0",  32'(we_d[0]), 32'h11);
    chk("w2_we_a1",  32'(we_a[1]), 32'h00);
    chk("w2_we_d1",  32'(we_d[1]), 32'h22);
    chk("w2_ptr",    32'(csr_a), 32'h01);

    // Pointer set, repeated START, read two bytes
    clear_log();
    start_c();
    send_byte(8'h94, ack);
    send_byte(8'h02, ack);
    start_c();
    send_byte(8'h95, ack); chk("r_addr_ack", 32'(ack), 32'h1);
    read_byte(1'b1, d);    chk("r_byte0",    32'(d), 32'h82);
    read_byte(1'b0, d);    chk("r_byte1",    32'(d), 32'h83);
    stop_c();
    chk("r_we_cnt", 32'(we_cnt), 32'd0);
    chk("r_ptr",    32'(csr_a), 32'h04);

    // Wrong address: no ACK, SDA never pulled, nothing written
    clear_log();
    start_c();
    oe_seen = 1'b0;
    send_byte(8'h96, ack); chk("bad_addr_ack", 32'(ack), 32'h0);
    send_byte(8'h05, ack); chk("bad_ptr_ack",  32'(ack), 32'h0);
    send_byte(8'h77, ack);
    stop_c();
    chk("bad_oe_seen", 32'(oe_seen), 32'h0);
    chk("bad_we_cnt",  32'(we_cnt), 32'd0);
    chk("bad_ptr",     32'(csr_a), 32'h04);

    // STOP after 4 data bits discards the partial byte
    clear_log();
    start_c();
    send_byte(8'h94, ack);
    send_byte(8'h06, ack);
    b = 8'hc3;
    for (int i = 7; i >= 4; i--) bit_c(b[i], r);
    stop_c();
    chk("stop_we_cnt", 32'(we_cnt), 32'd0);
    chk("stop_sda_oe", 32'(sda_oe), 32'h0);
    chk("stop_ptr",    32'(csr_a), 32'h06);

    // Reset asserted while the address ACK is being driven
    start_c();
    b = 8'h94;
    for (int i = 7; i >= 0; i--) bit_c(b[i], r);
    sda_m = 1'b1;
    tick(4);
    chk("rst_pre_oe", 32'(sda_oe), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rst_sda_oe", 32'(sda_oe), 32'h0);
    chk("rst_csr_a",  32'(csr_a),  32'h0);
    chk("rst_csr_do", 32'(csr_do), 32'h0);
    chk("rst_csr_we", 32'(csr_we), 32'h0);
    tick(2);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(4);

    // Recovery after reset: a normal write goes through
    clear_log();
    start_c();
    send_byte(8'h94, ack); chk("rec_addr_ack", 32'(ack), 32'h1);
    send_byte(8'h01, ack);
    send_byte(8'ha5, ack);
    stop_c();
    chk("rec_we_cnt", 32'(we_cnt), 32'd1);
    chk("rec_we_a",   32'(we_a[0]), 32'h01);
    chk("rec_we_d",   32'(we_d[0]), 32'ha5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
